// File: rtl/keypad_debounce8.sv
// keypad_debounce8: synchronises and debounces eight raw button lines and
// presents a single accepted press as a held one-hot vector plus a strobe.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   raw[7:0]   raw button lines, active high, asynchronous to clk
//   key[7:0]   one-hot accepted key, held while the key is down
//   key_valid  one-cycle strobe on each newly accepted press (and repeats)
//   busy       high while a key is accepted (PRESSED or RELEASE)
//
// Optional feature: define KEY_REPEAT_EN to re-strobe key_valid every
// REPEAT_CYCLES cycles while the accepted key remains held.
module keypad_debounce8 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       busy
);

    localparam int unsigned NK = 8;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Elaboration-time parameter range check
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
        $error("keypad_debounce8: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    logic [NK-1:0]         sync1_q, sync2_q;
    logic [NK-1:0]         db_q, db_d;
    logic [NK-1:0]         db_dly_q;
    logic [NK-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NK-1:0]         rise;
    logic [2:0]            rise_idx;
    state_t                state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [NK-1:0]         key_q, key_d;
    logic                  key_valid_q, key_valid_d;
    logic                  busy_q, busy_d;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0]         rep_q, rep_d, rep_inc;
`endif

    // Per-line debounce: toggle db only after DEBOUNCE_CYCLES differing samples
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int k = 0; k < NK; k++) begin
            if (sync2_q[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] + CW'(1) == CW'(DEBOUNCE_CYCLES)) begin
                db_d[k]  = ~db_q[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    // Rising edges of debounced lines; highest index wins
    assign rise = db_q & ~db_dly_q;

    always_comb begin
        rise_idx = 3'd0;
        for (int k = 0; k < NK; k++) begin
            if (rise[k]) rise_idx = 3'(k);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
        rep_inc     = rep_q + RW'(1);
`endif
        unique case (state_q)
            S_IDLE: begin
                key_d = '0;
                if (|rise) begin
                    sel_d       = rise_idx;
                    key_d       = NK'(1) << rise_idx;
                    key_valid_d = 1'b1;
                    state_d     = S_PRESSED;
`ifdef KEY_REPEAT_EN
                    rep_d       = '0;
`endif
                end
            end
            S_PRESSED: begin
                if (!db_q[sel_q]) begin
                    key_d   = '0;
                    state_d = S_RELEASE;
                end
`ifdef KEY_REPEAT_EN
                else if (rep_inc == RW'(REPEAT_CYCLES)) begin
                    key_valid_d = 1'b1;
                    rep_d       = '0;
                end else begin
                    rep_d = rep_inc;
                end
`endif
            end
            S_RELEASE: begin
                key_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                key_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_dly_q    <= '0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            sel_q       <= 3'd0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_dly_q    <= db_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_debounce8.sv
// Directed self-checking bench for keypad_debounce8 (default parameters).
module tb_keypad_debounce8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic [7:0] key;
    logic       key_valid;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    keypad_debounce8 dut (
        .clk       (clk),
        .rst       (rst),
        .raw       (raw),
        .key       (key),
        .key_valid (key_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1ns later; key must stay at most one-hot
    task automatic step();
        @(posedge clk);
        #1;
        check("onehot0", {7'd0, $onehot0(key)}, 8'h01);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // raw changed right after edge 0; expect acceptance after edge 7
    task automatic expect_press(input string tag, input logic [7:0] exp_key);
        for (int i = 1; i <= 6; i++) begin
            step();
            check({tag, "_pre_valid"}, {7'd0, key_valid}, 8'h00);
        end
        step();
        check({tag, "_key"}, key, exp_key);
        check({tag, "_valid"}, {7'd0, key_valid}, 8'h01);
        check({tag, "_busy"}, {7'd0, busy}, 8'h01);
    endtask

    // raw released right after edge 0; key drops after edge 7, busy after edge 8
    task automatic expect_release(input string tag, input logic [7:0] held_key);
        for (int i = 1; i <= 6; i++) begin
            step();
            check({tag, "_held"}, key, held_key);
        end
        step();
        check({tag, "_key0"}, key, 8'h00);
        check({tag, "_busy_rel"}, {7'd0, busy}, 8'h01);
        step();
        check({tag, "_busy0"}, {7'd0, busy}, 8'h00);
        check({tag, "_nostrobe"}, {7'd0, key_valid}, 8'h00);
    endtask

    initial begin
        logic [5:0] bounce_pat [12];
        rst = 1'b1;
        raw = 8'h00;
        #1;
        check("reset_key", key, 8'h00);
        check("reset_valid", {7'd0, key_valid}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        idle_steps(2);
        rst = 1'b0;
        idle_steps(3);

        // Single press of button 5
        raw = 8'h10;
        expect_press("single", 8'h10);
        step();
        check("single_valid_drop", {7'd0, key_valid}, 8'h00);
        check("single_key_hold", key, 8'h10);
        idle_steps(3);
        raw = 8'h00;
        expect_release("single_rel", 8'h10);
        idle_steps(3);

        // Bounce on raw[0]: alternating high/low runs, all highs shorter than 4
        bounce_pat = '{6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd1,
                       6'd3, 6'd2, 6'd1, 6'd1, 6'd2, 6'd1};
        for (int p = 0; p < 12; p++) begin
            raw = (p % 2 == 0) ? 8'h01 : 8'h00;
            for (int c = 0; c < int'(bounce_pat[p]); c++) begin
                step();
                check("bounce_valid", {7'd0, key_valid}, 8'h00);
                check("bounce_key", key, 8'h00);
            end
        end
        raw = 8'h01;
        expect_press("bounce", 8'h01);
        raw = 8'h00;
        expect_release("bounce_rel", 8'h01);
        idle_steps(3);

        // Simultaneous rises: highest index wins
        raw = 8'h81;
        expect_press("simul", 8'h80);
        idle_steps(2);
        raw = 8'h89;
        for (int i = 0; i < 12; i++) begin
            step();
            check("overlap_key", key, 8'h80);
            check("overlap_valid", {7'd0, key_valid}, 8'h00);
        end
        raw = 8'h08;
        expect_release("overlap_rel", 8'h80);
        for (int i = 0; i < 10; i++) begin
            step();
            check("dropped_key", key, 8'h00);
            check("dropped_valid", {7'd0, key_valid}, 8'h00);
        end
        raw = 8'h00;
        idle_steps(10);

        // Asynchronous reset mid-press, line still held afterwards
        raw = 8'h04;
        expect_press("prerst", 8'h04);
        idle_steps(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_key", key, 8'h00);
        check("async_rst_valid", {7'd0, key_valid}, 8'h00);
        check("async_rst_busy", {7'd0, busy}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_press("postrst", 8'h04);
        raw = 8'h00;
        expect_release("postrst_rel", 8'h04);
        idle_steps(3);

        // Long hold on button 6: repeat strobes only with KEY_REPEAT_EN
        raw = 8'h20;
        expect_press("hold", 8'h20);
        for (int i = 1; i <= 60; i++) begin
            logic exp_v;
`ifdef KEY_REPEAT_EN
            exp_v = (i % 16 == 0);
`else
            exp_v = 1'b0;
`endif
            step();
            check("hold_key", key, 8'h20);
            check("hold_valid", {7'd0, key_valid}, {7'd0, exp_v});
        end
        raw = 8'h00;
        expect_release("hold_rel", 8'h20);
        idle_steps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
